ps2_key_sequencer: RTL and testbench
====================================

// Module: ps2_key_sequencer
// PURPOSE
//  Sits between ps2_keyboard and the typing-game logic. Pops scan-code bytes
//  via the ready/nextdata_n handshake and folds F0/E0 prefixes into single key events.
//  Tracks shift/ctrl/caps state and buffers events in a FIFO read by the game at its own pace.
// PARAMETERS
//  FIFO_DEPTH  8   event FIFO entries; power of two, 2..64
//  REPEAT_EN   1   1: typematic repeat makes of non-modifier keys become events; 0: dropped
// PORTS
//  clk            in   1   system clock
//  clrn           in   1   asynchronous active-low reset
//  ps2_ready      in   1   ps2_keyboard has a byte available
//  ps2_byte       in   8   ps2_keyboard data output
//  ps2_overflow   in   1   ps2_keyboard internal FIFO overflow flag
//  ps2_nextdata_n out  1   active-low pop strobe to ps2_keyboard
//  evt_rd         in   1   consumer pops head event (ignored when evt_valid=0)
//  evt_valid      out  1   FIFO not empty
//  evt_code       out  8   head event scan code (prefix bytes stripped)
//  evt_break      out  1   head event is a release
//  evt_ext        out  1   head event was E0-prefixed
//  evt_upper      out  1   shift XOR caps at the moment the event was decoded
//  evt_ctrl       out  1   ctrl held at the moment the event was decoded
//  shift, ctrl, caps out 1 live modifier state; caps is the caps-lock toggle
//  key_count      out  16  accepted non-modifier make events, wraps at 16'hFFFF->0
//  drop_count     out  8   events lost to full FIFO or ps2_overflow; saturates at 8'hFF
// BEHAVIOUR
//  Reset (clrn=0, async): ps2_nextdata_n=1, FIFO empty, evt_valid=0, evt_* fields 0,
//   shift=ctrl=caps=0, key_count=0, drop_count=0, prefix flags clear, FSM=IDLE.
//  Handshake FSM (IDLE, POP, HOLD):
//   IDLE: ps2_ready=1 -> capture ps2_byte, go POP.
//   POP:  ps2_nextdata_n=0 for exactly this one cycle; go HOLD.
//   HOLD: ps2_nextdata_n=1; ps2_ready is not sampled this cycle; go IDLE.
//   => one byte consumed per 3 cycles max; never two pops for one byte.
//  Decode (on the captured byte, evaluated in POP):
//   8'hF0 -> brk_pend=1, no event. 8'hE0 -> ext_pend=1, no event.
//   other -> event {code, brk_pend, ext_pend}; both flags clear.
//   F0 then E0 order tolerated: flags are independent and set-only until an event.
//  Modifiers (non-extended codes 12/59 shift, 14 ctrl; E0 14 also ctrl):
//   shift = L_shift_held | R_shift_held (separately tracked); ctrl make=1, break=0.
//   caps (58): toggles on make only when caps_held=0; caps_held=1 on make, 0 on break.
//   Modifier events are still pushed to the FIFO (for game UI); never counted.
//   evt_upper/evt_ctrl use modifier state BEFORE the current event's own update.
//  Repeat filter: held[] bitmap of 128 non-extended codes (code[7] set -> never
//   filtered); make with held set = repeat: modifiers always dropped silently;
//   others pushed iff REPEAT_EN. Repeats never increment key_count.
//  FIFO: push on event, pop on evt_rd&evt_valid, head visible combinationally.
//   Full & push & no pop -> event dropped, drop_count+1 (sat).
//   Full & push & pop same cycle -> both occur, no drop. Empty & evt_rd -> ignored.
//  ps2_overflow rising edge -> drop_count+1 (sat), prefix flags cleared.
//  Latency: ps2_ready high at edge N -> event visible (evt_valid) after edge N+2.
//  key_count increments in the cycle the counted event is pushed (not if dropped).
// STRUCTURE
//  Package kbd_pkg: localparams SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12,
//   SC_RSHIFT=8'h59, SC_CTRL=8'h14, SC_CAPS=8'h58; event struct {code,brk,ext,upper,ctrl}.
//  One sub-module: key_evt_fifo (sync FIFO, width 12, depth FIFO_DEPTH, full/empty/wrap).
// TESTING
//  1C, F0, 1C -> two events {1C,brk0} then {1C,brk1}; key_count=1; 3 pops on nextdata_n.
//  12, 1C, F0 1C, F0 12 -> 1C make has evt_upper=1; shift=0 at end; key_count=1.
//  58, F0 58, 58, F0 58 -> caps 0->1->0; 1C after first pair has evt_upper=1.
//  E0 75, E0 F0 75 -> {75,ext1,brk0},{75,ext1,brk1}; key_count=1.
//  1C x3 (repeat), REPEAT_EN=0 -> one event, key_count=1; REPEAT_EN=1 -> three events, key_count=1.
//  FIFO_DEPTH=8, 10 makes, no evt_rd -> 8 events held, drop_count=2; clrn low mid-POP -> nextdata_n=1 at once.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared scan-code constants, event record and handshake states for the key sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam int EVT_W = 12;

  // One decoded key event as stored in the event FIFO.
  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       upper;
    logic       ctrl;
  } kbd_evt_t;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_POP  = 2'd1,
    HS_HOLD = 2'd2
  } hs_state_t;

  // Shift, ctrl and caps keys; only right ctrl exists in the extended set.
  function automatic logic is_modifier(input logic [7:0] code, input logic ext);
    if (ext) begin
      return (code == SC_CTRL);
    end
    return (code == SC_LSHIFT) || (code == SC_RSHIFT) ||
           (code == SC_CTRL)   || (code == SC_CAPS);
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous FIFO for key events with head word visible combinationally.
// Latency: a write is visible at the head the cycle after it is accepted.
// Backpressure: wr_rdy low when full unless a read happens the same cycle; reads when empty are ignored.
module key_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             full;
  logic             rd_fire;
  logic             wr_fire;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_fire = rd_rdy && !empty;
  assign wr_rdy  = !full || rd_fire;
  assign wr_fire = wr_vld && wr_rdy;
  assign rd_vld  = !empty;
  assign rd_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted writes and reads.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; a full-and-read cycle overwrites the slot being read out, which is safe.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Pops PS/2 scan bytes, folds F0/E0 prefixes into key events, tracks modifiers and queues events.
// Latency: ps2_ready sampled at edge N -> event at FIFO head after edge N+2; one byte per 3 cycles max.
// Backpressure: consumer pops via evt_rd at its own pace; a push into a full FIFO is dropped and counted.
module ps2_key_sequencer
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int REPEAT_EN  = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ps2_ready,
  input  logic [7:0]  ps2_byte,
  input  logic        ps2_overflow,
  output logic        ps2_nextdata_n,
  input  logic        evt_rd,
  output logic        evt_valid,
  output logic [7:0]  evt_code,
  output logic        evt_break,
  output logic        evt_ext,
  output logic        evt_upper,
  output logic        evt_ctrl,
  output logic        shift,
  output logic        ctrl,
  output logic        caps,
  output logic [15:0] key_count,
  output logic [7:0]  drop_count
);

  hs_state_t    state_q;
  hs_state_t    state_d;
  logic [7:0]   byte_q;
  logic         brk_pend_q;
  logic         ext_pend_q;
  logic         lshift_q;
  logic         rshift_q;
  logic         ctrl_q;
  logic         caps_q;
  logic         caps_held_q;
  logic [127:0] held_q;
  logic         ovf_q;
  logic         ovf_rise;

  logic         is_pop;
  logic         is_evt;
  logic         cur_mod;
  logic         filt;
  logic         rpt;
  logic         do_push;
  logic         do_cnt;
  kbd_evt_t     evt_d;

  kbd_evt_t     pend_evt_q;
  logic         pend_vld_q;
  logic         pend_cnt_q;

  logic         fifo_wr_rdy;
  logic         push_ok;
  logic         push_drop;
  kbd_evt_t     head;
  logic [EVT_W-1:0] fifo_rd_dat;

  logic [1:0]   drop_inc;
  logic [8:0]   drop_sum;

  // Handshake state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= HS_IDLE;
    else       state_q <= state_d;
  end

  // Handshake next state and the one-cycle active-low pop strobe.
  always_comb begin
    state_d        = state_q;
    ps2_nextdata_n = 1'b1;
    case (state_q)
      HS_IDLE: if (ps2_ready) state_d = HS_POP;
      HS_POP: begin
        ps2_nextdata_n = 1'b0;
        state_d        = HS_HOLD;
      end
      HS_HOLD: state_d = HS_IDLE;
      default: state_d = HS_IDLE;
    endcase
  end

  // Capture the byte offered by the keyboard when leaving IDLE.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                                byte_q <= '0;
    else if (state_q == HS_IDLE && ps2_ready) byte_q <= ps2_byte;
  end

  assign is_pop   = (state_q == HS_POP);
  assign ovf_rise = ps2_overflow && !ovf_q;

  // Decode of the captured byte; the event snapshots modifiers before its own update.
  always_comb begin
    is_evt      = is_pop && (byte_q != SC_BREAK) && (byte_q != SC_EXT);
    cur_mod     = is_modifier(byte_q, ext_pend_q);
    filt        = !ext_pend_q && !byte_q[7];
    rpt         = filt && !brk_pend_q && held_q[byte_q[6:0]];
    do_push     = is_evt && !(rpt && (cur_mod || (REPEAT_EN == 0)));
    do_cnt      = is_evt && !cur_mod && !brk_pend_q && !rpt;
    evt_d       = '0;
    evt_d.code  = byte_q;
    evt_d.brk   = brk_pend_q;
    evt_d.ext   = ext_pend_q;
    evt_d.upper = (lshift_q | rshift_q) ^ caps_q;
    evt_d.ctrl  = ctrl_q;
  end

  // Prefix flags are set-only until an event consumes them; overflow discards a partial sequence.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
    end else if (ovf_rise) begin
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
    end else if (is_pop) begin
      if (byte_q == SC_BREAK)   brk_pend_q <= 1'b1;
      else if (byte_q == SC_EXT) ext_pend_q <= 1'b1;
      else begin
        brk_pend_q <= 1'b0;
        ext_pend_q <= 1'b0;
      end
    end
  end

  // Held-key bitmap and modifier state, updated by every decoded event.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      held_q      <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      ctrl_q      <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else if (is_evt) begin
      if (filt) held_q[byte_q[6:0]] <= !brk_pend_q;
      if (!ext_pend_q && byte_q == SC_LSHIFT) lshift_q <= !brk_pend_q;
      if (!ext_pend_q && byte_q == SC_RSHIFT) rshift_q <= !brk_pend_q;
      if (byte_q == SC_CTRL)                  ctrl_q   <= !brk_pend_q;
      if (!ext_pend_q && byte_q == SC_CAPS) begin
        if (!brk_pend_q && !caps_held_q) caps_q <= !caps_q;
        caps_held_q <= !brk_pend_q;
      end
    end
  end

  // Decoded event waits one cycle here so the FIFO write lands during HOLD.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pend_vld_q <= 1'b0;
      pend_cnt_q <= 1'b0;
      pend_evt_q <= '0;
    end else begin
      pend_vld_q <= do_push;
      pend_cnt_q <= do_cnt;
      if (is_evt) pend_evt_q <= evt_d;
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk    (clk),
    .clrn   (clrn),
    .wr_vld (pend_vld_q),
    .wr_dat (pend_evt_q),
    .wr_rdy (fifo_wr_rdy),
    .rd_rdy (evt_rd),
    .rd_vld (evt_valid),
    .rd_dat (fifo_rd_dat)
  );

  assign head       = fifo_rd_dat;
  assign evt_code   = head.code;
  assign evt_break  = head.brk;
  assign evt_ext    = head.ext;
  assign evt_upper  = head.upper;
  assign evt_ctrl   = head.ctrl;
  assign shift      = lshift_q | rshift_q;
  assign ctrl       = ctrl_q;
  assign caps       = caps_q;

  assign push_ok    = pend_vld_q && fifo_wr_rdy;
  assign push_drop  = pend_vld_q && !fifo_wr_rdy;
  assign drop_inc   = {1'b0, push_drop} + {1'b0, ovf_rise};
  assign drop_sum   = {1'b0, drop_count} + {7'b0, drop_inc};

  // Overflow edge detector and the key/drop statistics.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ovf_q      <= 1'b0;
      key_count  <= '0;
      drop_count <= '0;
    end else begin
      ovf_q <= ps2_overflow;
      if (push_ok && pend_cnt_q) key_count <= key_count + 16'd1;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: scoreboarded event stream, modifier/counter checks, repeat filter on two builds.
// Latency: checks the N+2 event latency and the one-cycle pop strobe.
// Backpressure: consumer drains continuously except while the FIFO overflow case is exercised.
module tb_ps2_key_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        ps2_ready = 1'b0;
  logic [7:0]  ps2_byte = 8'h00;
  logic        ps2_overflow = 1'b0;
  logic        evt_rd = 1'b0;
  logic        evt_rd0 = 1'b1;

  logic        ps2_nextdata_n, nd0_n;
  logic        evt_valid, evt_break, evt_ext, evt_upper, evt_ctrl;
  logic [7:0]  evt_code;
  logic        shift, ctrl, caps;
  logic [15:0] key_count;
  logic [7:0]  drop_count;

  logic        evt_valid0, evt_break0, evt_ext0, evt_upper0, evt_ctrl0;
  logic [7:0]  evt_code0;
  logic        shift0, ctrl0, caps0;
  logic [15:0] key_count0;
  logic [7:0]  drop_count0;

  always #5 clk = ~clk;

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .REPEAT_EN(1)) dut (
    .clk(clk), .clrn(clrn), .ps2_ready(ps2_ready), .ps2_byte(ps2_byte),
    .ps2_overflow(ps2_overflow), .ps2_nextdata_n(ps2_nextdata_n), .evt_rd(evt_rd),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_break(evt_break), .evt_ext(evt_ext),
    .evt_upper(evt_upper), .evt_ctrl(evt_ctrl), .shift(shift), .ctrl(ctrl), .caps(caps),
    .key_count(key_count), .drop_count(drop_count)
  );

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .REPEAT_EN(0)) dut0 (
    .clk(clk), .clrn(clrn), .ps2_ready(ps2_ready), .ps2_byte(ps2_byte),
    .ps2_overflow(ps2_overflow), .ps2_nextdata_n(nd0_n), .evt_rd(evt_rd0),
    .evt_valid(evt_valid0), .evt_code(evt_code0), .evt_break(evt_break0), .evt_ext(evt_ext0),
    .evt_upper(evt_upper0), .evt_ctrl(evt_ctrl0), .shift(shift0), .ctrl(ctrl0), .caps(caps0),
    .key_count(key_count0), .drop_count(drop_count0)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_brk, m_ext, m_lsh, m_rsh, m_ctl, m_caps, m_caps_hold;
  bit          m_held [128];
  int          m_keys = 0;
  int          m_drops = 0;
  logic [11:0] exp_q [$];
  bit          drain_en = 1'b1;
  bit          force_rd = 1'b0;
  bit          lat_mode = 1'b0;
  int          pops = 0;
  int          ev0_cnt = 0;

  // Consumer: compares each head event against the scoreboard, then pops it.
  always @(negedge clk) begin
    if (drain_en) begin
      if (evt_valid) begin
        if (exp_q.size() == 0) chk("evt_unexpected", {31'b0, evt_valid}, 32'd0);
        else chk("evt", {20'b0, evt_code, evt_break, evt_ext, evt_upper, evt_ctrl}, {20'b0, exp_q.pop_front()});
        evt_rd = 1'b1;
      end else begin
        evt_rd = 1'b0;
      end
    end else begin
      evt_rd = force_rd;
    end
  end

  always @(negedge clk) begin
    if (!ps2_nextdata_n) pops++;
    if (evt_valid0) ev0_cnt++;
  end

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_lsh = 0; m_rsh = 0; m_ctl = 0; m_caps = 0; m_caps_hold = 0;
    for (int i = 0; i < 128; i++) m_held[i] = 0;
    m_keys = 0; m_drops = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic        mod, filt, rpt;
    logic [11:0] ev;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      mod  = m_ext ? (b == 8'h14) : (b == 8'h12 || b == 8'h59 || b == 8'h14 || b == 8'h58);
      filt = !m_ext && !b[7];
      rpt  = filt && !m_brk && m_held[b[6:0]];
      ev   = {b, m_brk, m_ext, (m_lsh | m_rsh) ^ m_caps, m_ctl};
      if (!(rpt && mod)) begin
        if (!drain_en && exp_q.size() >= DEPTH) begin
          if (m_drops < 255) m_drops++;
        end else begin
          exp_q.push_back(ev);
          if (!mod && !m_brk && !rpt) m_keys++;
        end
      end
      if (filt) m_held[b[6:0]] = !m_brk;
      if (!m_ext && b == 8'h12) m_lsh = !m_brk;
      if (!m_ext && b == 8'h59) m_rsh = !m_brk;
      if (b == 8'h14) m_ctl = !m_brk;
      if (!m_ext && b == 8'h58) begin
        if (!m_brk && !m_caps_hold) m_caps = !m_caps;
        m_caps_hold = !m_brk;
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    model_byte(b);
    @(negedge clk);
    ps2_byte  = b;
    ps2_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (ps2_nextdata_n && t < 8);
    chk("pop_seen", {31'b0, ps2_nextdata_n}, 32'd0);
    ps2_ready = 1'b0;
    if (lat_mode) chk("lat_pop", {31'b0, evt_valid}, 32'd0);
    @(negedge clk);
    chk("pop_width", {31'b0, ps2_nextdata_n}, 32'd1);
    if (lat_mode) chk("lat_hold", {31'b0, evt_valid}, 32'd0);
    @(negedge clk);
    if (lat_mode) chk("lat_push", {31'b0, evt_valid}, 32'd1);
  endtask

  task automatic ovf_pulse();
    @(negedge clk);
    ps2_overflow = 1'b1;
    @(negedge clk);
    ps2_overflow = 1'b0;
    if (m_drops < 255) m_drops++;
    m_brk = 0;
    m_ext = 0;
  endtask

  task automatic settle();
    int t = 0;
    while ((exp_q.size() != 0 || evt_valid) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) chk("drain_timeout", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_shift"}, {31'b0, shift}, {31'b0, m_lsh | m_rsh});
    chk({tag, "_ctrl"},  {31'b0, ctrl},  {31'b0, m_ctl});
    chk({tag, "_caps"},  {31'b0, caps},  {31'b0, m_caps});
    chk({tag, "_keys"},  {16'b0, key_count}, {16'b0, m_keys[15:0]});
    chk({tag, "_drops"}, {24'b0, drop_count}, m_drops);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, e0, t;
    logic [7:0] burst [10];
    burst = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_nd",    {31'b0, ps2_nextdata_n}, 32'd1);
    chk("rst_valid", {31'b0, evt_valid}, 32'd0);
    chk("rst_fields", {20'b0, evt_code, evt_break, evt_ext, evt_upper, evt_ctrl}, 32'd0);
    check_state("rst");
    clrn = 1'b1;
    @(negedge clk);

    // Plain make/break with latency check on the first byte
    p0 = pops;
    lat_mode = 1'b1;
    send_byte(8'h1C);
    lat_mode = 1'b0;
    send_byte(8'hF0);
    send_byte(8'h1C);
    settle();
    chk("t1_pops", pops - p0, 32'd3);
    check_state("t1");

    // Shifted key
    send_byte(8'h12);
    settle();
    chk("t2_shift_held", {31'b0, shift}, 32'd1);
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    settle();
    check_state("t2");

    // Caps lock toggle on, typed key, toggle off
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    settle();
    check_state("t3a");
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    settle();
    check_state("t3b");

    // Extended key make and break
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    settle();
    check_state("t4");

    // Typematic repeat: kept on the main build, dropped on the REPEAT_EN=0 build
    e0 = ev0_cnt;
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    settle();
    chk("t5_rep0_events", ev0_cnt - e0, 32'd1);
    chk("t5_rep0_keys", {16'b0, key_count0}, {16'b0, m_keys[15:0]});
    check_state("t5");
    send_byte(8'hF0); send_byte(8'h1C);
    settle();

    // Read on empty FIFO is ignored
    drain_en = 1'b0;
    force_rd = 1'b1;
    repeat (3) @(negedge clk);
    force_rd = 1'b0;
    repeat (2) @(negedge clk);
    chk("empty_rd", {31'b0, evt_valid}, 32'd0);

    // Fill past capacity with no consumer
    for (int i = 0; i < 10; i++) send_byte(burst[i]);
    @(negedge clk);
    chk("t6_valid", {31'b0, evt_valid}, 32'd1);
    check_state("t6");
    drain_en = 1'b1;
    settle();

    // Overflow discards a pending break prefix
    send_byte(8'hF0);
    ovf_pulse();
    send_byte(8'h1B);
    settle();
    check_state("t7");
    send_byte(8'hF0); send_byte(8'h1B);
    settle();

    // Asynchronous reset in the middle of a pop
    @(negedge clk);
    ps2_byte  = 8'h2A;
    ps2_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (ps2_nextdata_n && t < 8);
    chk("t8_pop_seen", {31'b0, ps2_nextdata_n}, 32'd0);
    clrn = 1'b0;
    #1;
    chk("t8_rst_nd", {31'b0, ps2_nextdata_n}, 32'd1);
    ps2_ready = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t8_valid", {31'b0, evt_valid}, 32'd0);
    check_state("t8");
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    chk("t8_idle_valid", {31'b0, evt_valid}, 32'd0);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) ovf_pulse();
    @(negedge clk);
    chk("t9_drop_sat", {24'b0, drop_count}, 32'hFF);
    check_state("t9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
